// File: rtl/oka_pkg.sv
// rtl/oka_pkg.sv - shared widths and helpers for the Karatsuba GF(2)[x] multiplier
// Contents:
//   W          operand width (233)
//   PW         unreduced product width (2*W-1 = 465)
//   LEVELS     Karatsuba recursion depth before the schoolbook leaves
//   ceil_half  split point m = ceil(n/2) used at every Karatsuba step
package oka_pkg;

  localparam int W      = 233;
  localparam int PW     = 2 * W - 1;
  localparam int LEVELS = 4;

  function automatic int ceil_half(input int n);
    return (n + 1) / 2;
  endfunction

endpackage

// File: rtl/oka_kara_step.sv
// rtl/oka_kara_step.sv - one recursive Karatsuba level of a carry-less multiplier
// Parameters:
//   N  operand width
//   L  remaining Karatsuba levels; 0 selects the schoolbook leaf
// Ports:
//   a  in  N      multiplicand, bit i = coefficient of x^i
//   b  in  N      multiplier, same ordering
//   y  out 2N-1   carry-less product a*b, unreduced
// Purely combinational.
module oka_kara_step
  import oka_pkg::*;
#(
  parameter int N = W,
  parameter int L = LEVELS
) (
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [2*N-2:0] y
);

  if (L > 0 && N > 1) begin : g_kara
    localparam int M  = ceil_half(N);
    localparam int PM = 2 * M - 1;

    logic [M-1:0]  a0, a1, b0, b1, am, bm;
    logic [PM-1:0] p0, p1, pm, mid;

    // High halves are N-M bits wide; the cast zero-extends them to M so all
    // three sub-products can share one child width.
    assign a0 = a[M-1:0];
    assign b0 = b[M-1:0];
    assign a1 = M'(a >> M);
    assign b1 = M'(b >> M);
    assign am = a0 ^ a1;
    assign bm = b0 ^ b1;

    oka_kara_step #(.N(M), .L(L - 1)) u_p0 (.a(a0), .b(b0), .y(p0));
    oka_kara_step #(.N(M), .L(L - 1)) u_p1 (.a(a1), .b(b1), .y(p1));
    oka_kara_step #(.N(M), .L(L - 1)) u_pm (.a(am), .b(bm), .y(pm));

    // mid = a0*b1 ^ a1*b0, degree <= N-2, so shifting it by M never
    // overflows 2N-1 bits; likewise P1 has degree <= 2(N-M)-2.
    assign mid = p0 ^ p1 ^ pm;
    assign y   = (2*N-1)'(p0)
               ^ ((2*N-1)'(mid) << M)
               ^ ((2*N-1)'(p1) << (2 * M));
  end else begin : g_leaf
    always_comb begin
      y = '0;
      for (int j = 0; j < N; j++) begin
        y = y ^ ((2*N-1)'(a & {N{b[j]}}) << j);
      end
    end
  end

endmodule

// File: rtl/oka_233bit.sv
// rtl/oka_233bit.sv - registered 233-bit carry-less multiplier, 465-bit unreduced product
// Ports:
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous active-high reset
//   in_valid   in   1      a/b carry a new operand pair
//   a, b       in   W      operands, bit i = coefficient of x^i
//   out_valid  out  1      y holds the product of a pair accepted LAT cycles ago
//   y          out  2W-1   carry-less product a*b over GF(2)
// Build option OKA_233_IN_REG_EN: adds an input register stage (LAT = 2);
// otherwise a/b feed the core directly (LAT = 1).
module oka_233bit #(
  parameter int W      = oka_pkg::W,
  parameter int LEVELS = oka_pkg::LEVELS
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           out_valid,
  output logic [2*W-2:0] y
);

  logic [W-1:0]   core_a, core_b;
  logic           core_v;
  logic [2*W-2:0] prod;

`ifdef OKA_233_IN_REG_EN
  logic [W-1:0] a_q, b_q;
  logic         v_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
      v_q <= 1'b0;
    end else begin
      a_q <= a;
      b_q <= b;
      v_q <= in_valid;
    end
  end

  assign core_a = a_q;
  assign core_b = b_q;
  assign core_v = v_q;
`else
  assign core_a = a;
  assign core_b = b;
  assign core_v = in_valid;
`endif

  oka_kara_step #(.N(W), .L(LEVELS)) u_core (
    .a (core_a),
    .b (core_b),
    .y (prod)
  );

  // The datapath is not gated by valid; only out_valid tracks it.
  always_ff @(posedge clk) begin
    if (rst) begin
      y         <= '0;
      out_valid <= 1'b0;
    end else begin
      y         <= prod;
      out_valid <= core_v;
    end
  end

endmodule

// File: tb/tb_oka_233bit.sv
// tb/tb_oka_233bit.sv - scoreboard bench for oka_233bit
module tb_oka_233bit;

  localparam int W  = 233;
  localparam int PW = 2 * W - 1;
`ifdef OKA_233_IN_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          out_valid;
  logic [PW-1:0] y;

  oka_233bit dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .y         (y)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [PW-1:0] y;
    int            cyc;
    string         name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [PW-1:0] clmul(input logic [W-1:0] x, input logic [W-1:0] z);
    logic [PW-1:0] r;
    r = '0;
    for (int i = 0; i < W; i++) begin
      if (z[i]) r = r ^ (PW'(x) << i);
    end
    return r;
  endfunction

  function automatic logic [W-1:0] rnd();
    logic [255:0] t;
    for (int k = 0; k < 8; k++) t[k*32 +: 32] = $urandom;
    return t[W-1:0];
  endfunction

  // Monitor: every out_valid cycle is matched against the scoreboard head.
  always @(negedge clk) begin
    if (mon_en) begin
      if (out_valid === 1'b1) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_out_valid cyc=%0d y=%h", cyc, y);
        end else begin
          exp_t e;
          e = sb.pop_front();
          n_checks++;
          if (y !== e.y) begin
            n_fail++;
            $display("FAIL %s_y cyc=%0d got=%h exp=%h", e.name, cyc, y, e.y);
          end
          n_checks++;
          if (cyc != e.cyc) begin
            n_fail++;
            $display("FAIL %s_latency got_cyc=%0d exp_cyc=%0d", e.name, cyc, e.cyc);
          end
        end
      end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
        n_checks++;
        n_fail++;
        $display("FAIL %s_missing cyc=%0d out_valid=%b exp_cyc=%0d", sb[0].name, cyc, out_valid, sb[0].cyc);
        void'(sb.pop_front());
      end
    end
  end

  // Inputs change #1 after a rising edge; an accepted pair shows up at the
  // negedge LAT cycles later.
  task automatic drive(input logic v, input logic [W-1:0] aa, input logic [W-1:0] bb,
                       input logic [PW-1:0] ey, input string nm, input logic r);
    exp_t e;
    rst      = r;
    in_valid = v;
    a        = aa;
    b        = bb;
    if (v && !r) begin
      e.y    = ey;
      e.cyc  = cyc + LAT;
      e.name = nm;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    if (r) sb.delete();
  endtask

  task automatic check_idle(input string nm);
    n_checks++;
    if (out_valid !== 1'b0 || y !== '0) begin
      n_fail++;
      $display("FAIL %s got out_valid=%b y=%h exp out_valid=0 y=0", nm, out_valid, y);
    end
  endtask

  task automatic reset_phase(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      rst      = 1'b1;
      in_valid = 1'b1;
      a        = rnd();
      b        = rnd();
      @(posedge clk);
      #1;
      sb.delete();
      check_idle("reset_hold");
    end
    rst      = 1'b0;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    for (int i = 0; i < LAT; i++) begin
      @(posedge clk);
      #1;
      check_idle("post_reset");
    end
  endtask

  logic [W-1:0]  one_v, three_v, top_v, ones_v, va, vb, ra, rb;
  logic [PW-1:0] e_one, e_nine, e_top, e_ones;

  initial begin
    one_v   = '0; one_v[0] = 1'b1;
    three_v = '0; three_v[1:0] = 2'b11;
    top_v   = '0; top_v[W-1] = 1'b1;
    ones_v  = '1;
    e_one   = '0; e_one[0] = 1'b1;
    e_nine  = '0; e_nine[2:0] = 3'b101;
    e_top   = '0; e_top[PW-1] = 1'b1;
    e_ones  = '0; e_ones[W-1:0] = '1;
    va = '0; va[79:0] = 80'hABABABABABABABABABAB;
    vb = '0; vb[79:0] = 80'hFABF57EAAFD57EAAFD57;

    @(posedge clk);
    #1;
    reset_phase(3);
    mon_en = 1'b1;

    drive(1'b1, one_v,   one_v,   e_one,  "one_sq",   1'b0);
    drive(1'b1, three_v, three_v, e_nine, "three_sq", 1'b0);
    drive(1'b1, top_v,   top_v,   e_top,  "top_sq",   1'b0);
    drive(1'b1, ones_v,  one_v,   e_ones, "ones_x1",  1'b0);
    drive(1'b1, vb,      one_v,   PW'(vb), "vb_x1",   1'b0);
    drive(1'b1, va,      vb,      clmul(va, vb), "regress", 1'b0);
    drive(1'b0, rnd(),   rnd(),   '0,     "idle",     1'b0);
    drive(1'b1, vb,      va,      clmul(va, vb), "regress_swap", 1'b0);

    for (int i = 0; i < 1000; i++) begin
      logic v, r;
      v  = ($urandom_range(0, 3) != 0);
      r  = (i >= 500 && i < 502);
      ra = rnd();
      rb = rnd();
      drive(v, ra, rb, clmul(ra, rb), "stream", r);
    end

    for (int k = 0; k < 10 && sb.size() != 0; k++) begin
      drive(1'b0, '0, '0, '0, "drain", 1'b0);
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout pending=%0d exp=0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
